// File: rtl/xxv_ptp_pkg.sv
// rtl/xxv_ptp_pkg.sv - shared constants and helpers for the XXV PTP tag tracker
package xxv_ptp_pkg;
    localparam int TAG_W = 16;
    localparam int TS_W  = 80;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_1STEP = 2'b01;
    localparam logic [1:0] OP_2STEP = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_MISMATCH = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;
    localparam logic [1:0] ST_DROPPED  = 2'b11;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        sat_inc = (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction
endpackage

// File: rtl/xxv_ptp_sync_fifo.sv
// rtl/xxv_ptp_sync_fifo.sv - first-word-fall-through synchronous FIFO
module xxv_ptp_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    // Writes to a full FIFO and reads from an empty one are ignored.
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so an idle head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + CW'(1);
            end else if (!do_wr && do_rd) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: rtl/xxv_ptp_tag_tracker.sv
// rtl/xxv_ptp_tag_tracker.sv - multi-outstanding two-step PTP tag tracker for the XXV MAC TX path
module xxv_ptp_tag_tracker
    import xxv_ptp_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CTRL_DEPTH      = 8,
    parameter int OUT_DEPTH       = 8,
    parameter int TIMEOUT_CYC     = 65535
) (
    input  logic          tx_eth_clk,
    input  logic          tx_eth_aresetn,
    input  logic [31:0]   tx_ptp_ctrl_tdata,
    input  logic          tx_ptp_ctrl_tvalid,
    input  logic          tx_ptp_ctrl_tlast,
    output logic          tx_ptp_ctrl_tready,
    input  logic          tx_eth_tvalid,
    input  logic          tx_eth_tready,
    input  logic          tx_eth_tuser,
    input  logic          tx_eth_tlast,
    output logic [1:0]    tx_ptp_1588op,
    output logic [15:0]   tx_ptp_tag_field,
    input  logic          tx_ptp_tstamp_valid_in,
    input  logic [15:0]   tx_ptp_tstamp_tag_in,
    input  logic [79:0]   tx_ptp_tstamp_in,
    output logic [95:0]   tx_ptp_ts_tdata,
    output logic [1:0]    tx_ptp_ts_tuser,
    output logic          tx_ptp_ts_tvalid,
    output logic          tx_ptp_ts_tlast,
    input  logic          tx_ptp_ts_tready,
    output logic [4:0]    outstanding,
    output logic [15:0]   stat_timeout,
    output logic [15:0]   stat_mismatch,
    output logic [15:0]   stat_drop,
    output logic [15:0]   stat_ovf
);
    localparam int PCW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int CCW = $clog2(CTRL_DEPTH) + 1;
    localparam int OCW = $clog2(OUT_DEPTH) + 1;
    localparam int REC_W = 2 + TAG_W + TS_W;
    localparam logic [19:0] AGE_LIM = 20'(TIMEOUT_CYC - 1);

    logic                 rst_done, in_pkt, drop_pend;
    logic [1:0]           op_lat;
    logic [TAG_W-1:0]     tag_lat, drop_tag;
    logic [19:0]          age;
    logic                 ctrl_full, ctrl_empty, pend_full, pend_empty, out_full, out_empty;
    logic [CCW-1:0]       ctrl_count;
    logic [PCW-1:0]       pend_count;
    logic [OCW-1:0]       out_count;
    logic [TAG_W+1:0]     ctrl_head;
    logic [TAG_W-1:0]     pend_head;
    logic [REC_W-1:0]     out_head;
    logic                 beat, sop, arm_sop, ctrl_push, ctrl_pop, two_step;
    logic                 drop_full, drop_empty, pend_push, pend_pop, strobe, timeout;
    logic [1:0]           head_op, sop_op;
    logic [TAG_W-1:0]     sop_tag;
    logic                 rec_valid, drop_wr, mismatch_evt;
    logic [1:0]           rec_status;
    logic [TAG_W+TS_W-1:0] rec_data;
    logic                 unused_sig;

    assign unused_sig = ^{tx_ptp_ctrl_tlast, tx_ptp_ctrl_tdata[15:2], ctrl_count, out_count};

    assign tx_ptp_ctrl_tready = rst_done & ~ctrl_full;
    assign ctrl_push  = tx_ptp_ctrl_tvalid & tx_ptp_ctrl_tready;
    assign beat       = tx_eth_tvalid & tx_eth_tready;
    assign sop        = beat & ~in_pkt;
    assign arm_sop    = sop & tx_eth_tuser;
    assign head_op    = (ctrl_head[1:0] == OP_RSVD) ? OP_NONE : ctrl_head[1:0];
    assign ctrl_pop   = arm_sop & ~ctrl_empty;
    assign two_step   = ctrl_pop & (head_op == OP_2STEP);
    assign drop_full  = two_step & pend_full;
    assign pend_push  = two_step & ~pend_full;
    assign drop_empty = arm_sop & ctrl_empty;
    assign sop_op     = (ctrl_empty | drop_full) ? OP_NONE : head_op;
    assign sop_tag    = ctrl_empty ? '0 : ctrl_head[TAG_W+1:2];

    // The SOP beat sees the ctrl head directly; later beats see the per-packet latch.
    assign tx_ptp_1588op    = tx_eth_tuser ? (in_pkt ? op_lat : sop_op) : OP_NONE;
    assign tx_ptp_tag_field = tx_eth_tuser ? (in_pkt ? tag_lat : sop_tag) : '0;

    assign strobe       = tx_ptp_tstamp_valid_in;
    assign timeout      = ~pend_empty & ~strobe & (age == AGE_LIM);
    assign pend_pop     = (strobe & ~pend_empty) | timeout;
    assign mismatch_evt = strobe & (pend_empty | (tx_ptp_tstamp_tag_in != pend_head));
    assign outstanding  = 5'(pend_count);

    // One record per cycle: timestamp strobe beats timeout, timeout beats a parked drop.
    always_comb begin
        rec_valid  = 1'b0;
        rec_status = ST_OK;
        rec_data   = '0;
        drop_wr    = 1'b0;
        if (strobe) begin
            rec_valid  = 1'b1;
            rec_status = mismatch_evt ? ST_MISMATCH : ST_OK;
            rec_data   = {tx_ptp_tstamp_tag_in, tx_ptp_tstamp_in};
        end else if (timeout) begin
            rec_valid  = 1'b1;
            rec_status = ST_TIMEOUT;
            rec_data   = {pend_head, {TS_W{1'b0}}};
        end else if (drop_pend) begin
            rec_valid  = 1'b1;
            rec_status = ST_DROPPED;
            rec_data   = {drop_tag, {TS_W{1'b0}}};
            drop_wr    = 1'b1;
        end
    end

    // Packet framing, per-packet op/tag latch and the ctrl ready enable after reset.
    always_ff @(posedge tx_eth_clk or negedge tx_eth_aresetn) begin
        if (!tx_eth_aresetn) begin
            rst_done <= 1'b0;
            in_pkt   <= 1'b0;
            op_lat   <= OP_NONE;
            tag_lat  <= '0;
        end else begin
            rst_done <= 1'b1;
            if (beat) begin
                in_pkt <= ~tx_eth_tlast;
            end
            if (arm_sop) begin
                op_lat  <= sop_op;
                tag_lat <= sop_tag;
            end else if (sop) begin
                op_lat  <= OP_NONE;
                tag_lat <= '0;
            end
        end
    end

    // Head age restarts whenever a different entry becomes the head.
    always_ff @(posedge tx_eth_clk or negedge tx_eth_aresetn) begin
        if (!tx_eth_aresetn) begin
            age <= '0;
        end else if (pend_pop || (pend_push && pend_empty)) begin
            age <= '0;
        end else if (!pend_empty) begin
            age <= age + 20'd1;
        end
    end

    // A dropped two-step tag parks here until a record slot is free; only one is held.
    always_ff @(posedge tx_eth_clk or negedge tx_eth_aresetn) begin
        if (!tx_eth_aresetn) begin
            drop_pend <= 1'b0;
            drop_tag  <= '0;
        end else if (drop_wr) begin
            drop_pend <= 1'b0;
        end else if (drop_full && !drop_pend) begin
            drop_pend <= 1'b1;
            drop_tag  <= ctrl_head[TAG_W+1:2];
        end
    end

    // Saturating event counters.
    always_ff @(posedge tx_eth_clk or negedge tx_eth_aresetn) begin
        if (!tx_eth_aresetn) begin
            stat_timeout  <= '0;
            stat_mismatch <= '0;
            stat_drop     <= '0;
            stat_ovf      <= '0;
        end else begin
            stat_timeout  <= sat_inc(stat_timeout, timeout);
            stat_mismatch <= sat_inc(stat_mismatch, mismatch_evt);
            stat_drop     <= sat_inc(stat_drop, drop_empty | drop_full);
            stat_ovf      <= sat_inc(stat_ovf, rec_valid & out_full);
        end
    end

    xxv_ptp_sync_fifo #(.DATA_W(TAG_W + 2), .DEPTH(CTRL_DEPTH)) u_ctrl_fifo (
        .clk(tx_eth_clk), .rst_n(tx_eth_aresetn),
        .wr_en(ctrl_push), .wr_data({tx_ptp_ctrl_tdata[31:16], tx_ptp_ctrl_tdata[1:0]}),
        .rd_en(ctrl_pop), .rd_data(ctrl_head),
        .full(ctrl_full), .empty(ctrl_empty), .count(ctrl_count)
    );

    xxv_ptp_sync_fifo #(.DATA_W(TAG_W), .DEPTH(MAX_OUTSTANDING)) u_pend_fifo (
        .clk(tx_eth_clk), .rst_n(tx_eth_aresetn),
        .wr_en(pend_push), .wr_data(ctrl_head[TAG_W+1:2]),
        .rd_en(pend_pop), .rd_data(pend_head),
        .full(pend_full), .empty(pend_empty), .count(pend_count)
    );

    xxv_ptp_sync_fifo #(.DATA_W(REC_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk(tx_eth_clk), .rst_n(tx_eth_aresetn),
        .wr_en(rec_valid), .wr_data({rec_status, rec_data}),
        .rd_en(tx_ptp_ts_tready), .rd_data(out_head),
        .full(out_full), .empty(out_empty), .count(out_count)
    );

    assign tx_ptp_ts_tvalid = ~out_empty;
    assign tx_ptp_ts_tlast  = ~out_empty;
    assign tx_ptp_ts_tuser  = out_head[REC_W-1 -: 2];
    assign tx_ptp_ts_tdata  = out_head[TAG_W+TS_W-1:0];
endmodule

// File: tb/tb_xxv_ptp_tag_tracker.sv
// tb/tb_xxv_ptp_tag_tracker.sv - self-checking bench for xxv_ptp_tag_tracker
module tb_xxv_ptp_tag_tracker;
    localparam int MAXO = 4;
    localparam int CD   = 8;
    localparam int OD   = 8;
    localparam int TO   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic [31:0] ctrl_tdata;
    logic ctrl_tvalid, ctrl_tready, eth_tvalid, eth_tready, eth_tuser, eth_tlast;
    logic [1:0] op;
    logic [15:0] tag;
    logic strobe;
    logic [15:0] stag;
    logic [79:0] sts;
    logic [95:0] ts_tdata;
    logic [1:0] ts_tuser;
    logic ts_tvalid, ts_tlast, ts_tready;
    logic [4:0] outstanding;
    logic [15:0] st_to, st_mis, st_drop, st_ovf;

    xxv_ptp_tag_tracker #(.MAX_OUTSTANDING(MAXO), .CTRL_DEPTH(CD), .OUT_DEPTH(OD), .TIMEOUT_CYC(TO)) dut (
        .tx_eth_clk(clk), .tx_eth_aresetn(rst_n),
        .tx_ptp_ctrl_tdata(ctrl_tdata), .tx_ptp_ctrl_tvalid(ctrl_tvalid),
        .tx_ptp_ctrl_tlast(ctrl_tvalid), .tx_ptp_ctrl_tready(ctrl_tready),
        .tx_eth_tvalid(eth_tvalid), .tx_eth_tready(eth_tready),
        .tx_eth_tuser(eth_tuser), .tx_eth_tlast(eth_tlast),
        .tx_ptp_1588op(op), .tx_ptp_tag_field(tag),
        .tx_ptp_tstamp_valid_in(strobe), .tx_ptp_tstamp_tag_in(stag), .tx_ptp_tstamp_in(sts),
        .tx_ptp_ts_tdata(ts_tdata), .tx_ptp_ts_tuser(ts_tuser),
        .tx_ptp_ts_tvalid(ts_tvalid), .tx_ptp_ts_tlast(ts_tlast), .tx_ptp_ts_tready(ts_tready),
        .outstanding(outstanding),
        .stat_timeout(st_to), .stat_mismatch(st_mis), .stat_drop(st_drop), .stat_ovf(st_ovf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [17:0] m_ctrl[$];
    logic [15:0] m_pend[$];
    logic [97:0] m_out[$];
    int          cyc = 0;
    int          m_head_since;
    bit          m_in_pkt, m_drop_pend, m_ready;
    logic [1:0]  m_op_lat;
    logic [15:0] m_tag_lat, m_drop_tag;
    int          m_to, m_mis, m_drop, m_ovf;

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_ctrl.delete(); m_pend.delete(); m_out.delete();
        m_in_pkt = 0; m_drop_pend = 0; m_ready = 0;
        m_op_lat = 0; m_tag_lat = 0; m_drop_tag = 0; m_head_since = 0;
        m_to = 0; m_mis = 0; m_drop = 0; m_ovf = 0;
    endtask

    task automatic model_compare();
        logic [1:0]  eop;
        logic [15:0] etag;
        logic [1:0]  hop;
        chk("tready", ctrl_tready, (m_ready && m_ctrl.size() < CD));
        chk("outstanding", outstanding, m_pend.size());
        chk("ts_tvalid", ts_tvalid, m_out.size() > 0);
        chk("ts_tlast", ts_tlast, m_out.size() > 0);
        if (m_out.size() > 0) begin
            chk("ts_tuser", ts_tuser, m_out[0][97:96]);
            chk("ts_tdata", ts_tdata, m_out[0][95:0]);
        end
        chk("stat_timeout", st_to, m_to);
        chk("stat_mismatch", st_mis, m_mis);
        chk("stat_drop", st_drop, m_drop);
        chk("stat_ovf", st_ovf, m_ovf);
        if (eth_tvalid && eth_tready) begin
            eop = 0; etag = 0;
            if (eth_tuser) begin
                if (m_in_pkt) begin
                    eop = m_op_lat; etag = m_tag_lat;
                end else if (m_ctrl.size() > 0) begin
                    hop  = m_ctrl[0][1:0];
                    eop  = (hop == 2'b11 || (hop == 2'b10 && m_pend.size() == MAXO)) ? 2'b00 : hop;
                    etag = m_ctrl[0][17:2];
                end
            end
            chk("beat_op", op, eop);
            chk("beat_tag", tag, etag);
        end
    endtask

    task automatic model_step();
        int ps = m_pend.size();
        int os = m_out.size();
        int cs = m_ctrl.size();
        bit dp = m_drop_pend;
        bit rv = 0;
        logic [97:0] r = '0;
        logic [15:0] h;
        logic [17:0] w;
        logic [1:0]  o;
        if (strobe) begin
            rv = 1;
            if (ps == 0) begin
                r = {2'b01, stag, sts}; m_mis = sat(m_mis);
            end else begin
                h = m_pend.pop_front(); m_head_since = cyc + 1;
                if (h == stag) r = {2'b00, stag, sts};
                else begin r = {2'b01, stag, sts}; m_mis = sat(m_mis); end
            end
        end else if (ps > 0 && (cyc - m_head_since) == TO - 1) begin
            h = m_pend.pop_front(); m_head_since = cyc + 1;
            r = {2'b10, h, 80'd0}; rv = 1; m_to = sat(m_to);
        end else if (dp) begin
            r = {2'b11, m_drop_tag, 80'd0}; rv = 1; m_drop_pend = 0;
        end
        if (eth_tvalid && eth_tready && !m_in_pkt) begin
            m_op_lat = 0; m_tag_lat = 0;
            if (eth_tuser) begin
                if (cs == 0) m_drop = sat(m_drop);
                else begin
                    w = m_ctrl.pop_front();
                    o = (w[1:0] == 2'b11) ? 2'b00 : w[1:0];
                    if (o == 2'b10) begin
                        if (ps == MAXO) begin
                            m_drop = sat(m_drop); o = 2'b00;
                            if (!dp) begin m_drop_pend = 1; m_drop_tag = w[17:2]; end
                        end else begin
                            if (ps == 0) m_head_since = cyc + 1;
                            m_pend.push_back(w[17:2]);
                        end
                    end
                    m_op_lat = o; m_tag_lat = w[17:2];
                end
            end
        end
        if (eth_tvalid && eth_tready) m_in_pkt = !eth_tlast;
        if (ctrl_tvalid && m_ready && cs < CD) m_ctrl.push_back({ctrl_tdata[31:16], ctrl_tdata[1:0]});
        if (os > 0 && ts_tready) void'(m_out.pop_front());
        if (rv) begin
            if (os == OD) m_ovf = sat(m_ovf);
            else m_out.push_back(r);
        end
        m_ready = 1;
    endtask

    // Compare process: one check pass and one model step per cycle, mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        else begin
            model_compare();
            model_step();
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ctrl_tvalid = 0; ctrl_tdata = 0; eth_tvalid = 0; eth_tready = 0;
        eth_tuser = 0; eth_tlast = 0; strobe = 0; stag = 0; sts = 0; ts_tready = 1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick(); tick();
        #2;
        chk("rst_op", op, 2'b00);
        chk("rst_tvalid", ts_tvalid, 1'b0);
        chk("rst_tdata", ts_tdata, 96'd0);
        chk("rst_outstanding", outstanding, 5'd0);
        chk("rst_tready", ctrl_tready, 1'b0);
        chk("rst_stats", {st_to, st_mis, st_drop, st_ovf}, 64'd0);
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic push_ctrl(input logic [15:0] t, input logic [1:0] o);
        ctrl_tvalid = 1; ctrl_tdata = {t, 14'd0, o};
        tick();
        ctrl_tvalid = 0;
    endtask

    task automatic one_beat_pkt(input logic user);
        eth_tvalid = 1; eth_tready = 1; eth_tuser = user; eth_tlast = 1;
    endtask

    task automatic end_pkt();
        eth_tvalid = 0; eth_tlast = 0; eth_tuser = 0;
    endtask

    int drained;

    initial begin
        idle();
        // 1: two-step tag applied to all beats, OK record
        do_reset();
        push_ctrl(16'h0011, 2'b10);
        ts_tready = 0;
        for (int b = 0; b < 3; b++) begin
            eth_tvalid = 1; eth_tready = 1; eth_tuser = 1; eth_tlast = (b == 2);
            #2;
            chk("t1_op", op, 2'b10);
            chk("t1_tag", tag, 16'h0011);
            tick();
        end
        end_pkt();
        strobe = 1; stag = 16'h0011; sts = 80'h5;
        tick();
        strobe = 0;
        #2;
        chk("t1_rec_valid", ts_tvalid, 1'b1);
        chk("t1_rec_status", ts_tuser, 2'b00);
        chk("t1_rec_data", ts_tdata, {16'h0011, 80'h5});
        tick();

        // 2: table full -> fifth two-step dropped
        do_reset();
        ts_tready = 0;
        for (int t = 0; t < 5; t++) push_ctrl(16'h0021 + 16'(t), 2'b10);
        for (int p = 0; p < 4; p++) begin one_beat_pkt(1); tick(); end
        one_beat_pkt(1);
        #2;
        chk("t2_fifth_op", op, 2'b00);
        tick();
        end_pkt();
        #2;
        chk("t2_outstanding", outstanding, 5'd4);
        chk("t2_stat_drop", st_drop, 16'd1);
        tick();
        #2;
        chk("t2_drop_status", ts_tuser, 2'b11);
        chk("t2_drop_data", ts_tdata, {16'h0025, 80'd0});
        tick();

        // 3a: head ages out after TIMEOUT_CYC clocks
        do_reset();
        ts_tready = 0;
        push_ctrl(16'h0031, 2'b10);
        one_beat_pkt(1); tick(); end_pkt();
        repeat (15) tick();
        #2;
        chk("t3_no_rec_yet", ts_tvalid, 1'b0);
        chk("t3_still_pending", outstanding, 5'd1);
        tick();
        #2;
        chk("t3_to_status", ts_tuser, 2'b10);
        chk("t3_to_data", ts_tdata, {16'h0031, 80'd0});
        chk("t3_stat_timeout", st_to, 16'd1);
        // 3b: strobe on the timeout cycle wins
        do_reset();
        ts_tready = 0;
        push_ctrl(16'h0032, 2'b10);
        one_beat_pkt(1); tick(); end_pkt();
        repeat (15) tick();
        strobe = 1; stag = 16'h0032; sts = 80'h77;
        tick();
        strobe = 0;
        #2;
        chk("t3b_status", ts_tuser, 2'b00);
        chk("t3b_data", ts_tdata, {16'h0032, 80'h77});
        chk("t3b_stat_timeout", st_to, 16'd0);

        // 4: out-of-order return -> mismatch, head popped
        do_reset();
        ts_tready = 0;
        push_ctrl(16'h0001, 2'b10);
        push_ctrl(16'h0002, 2'b10);
        one_beat_pkt(1); tick(); tick(); end_pkt();
        strobe = 1; stag = 16'h0002; sts = 80'h99;
        tick();
        strobe = 0;
        #2;
        chk("t4_status", ts_tuser, 2'b01);
        chk("t4_data", ts_tdata, {16'h0002, 80'h99});
        chk("t4_outstanding", outstanding, 5'd1);
        chk("t4_stat_mismatch", st_mis, 16'd1);

        // 5: output FIFO overflow
        do_reset();
        ts_tready = 0;
        for (int i = 0; i < 9; i++) begin
            strobe = 1; stag = 16'(i); sts = 80'(i);
            tick();
        end
        strobe = 0;
        #2;
        chk("t5_stat_ovf", st_ovf, 16'd1);
        chk("t5_stat_mismatch", st_mis, 16'd9);
        tick();
        ts_tready = 1;
        drained = 0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (ts_tvalid) drained++;
            tick();
        end
        chk("t5_drained", drained, 8);

        // 6: empty ctrl FIFO, non-ARM packet, reset mid-packet
        do_reset();
        one_beat_pkt(1);
        #2;
        chk("t6_empty_op", op, 2'b00);
        tick(); end_pkt();
        #2;
        chk("t6_stat_drop", st_drop, 16'd1);
        push_ctrl(16'h0061, 2'b01);
        one_beat_pkt(0);
        #2;
        chk("t6_nonarm_op", op, 2'b00);
        tick();
        one_beat_pkt(1);
        #2;
        chk("t6_arm_op", op, 2'b01);
        chk("t6_arm_tag", tag, 16'h0061);
        tick(); end_pkt();
        push_ctrl(16'h0062, 2'b10);
        eth_tvalid = 1; eth_tready = 1; eth_tuser = 1; eth_tlast = 0;
        tick();
        rst_n = 0;
        #2;
        chk("t6_rst_op", op, 2'b00);
        chk("t6_rst_tag", tag, 16'd0);
        chk("t6_rst_outstanding", outstanding, 5'd0);
        chk("t6_rst_tready", ctrl_tready, 1'b0);
        tick();
        rst_n = 1;
        #2;
        chk("t6_post_rst_op", op, 2'b00);
        tick();
        eth_tlast = 1;
        #2;
        chk("t6_post_rst_drop", st_drop, 16'd1);
        tick();
        end_pkt();

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ctrl_tvalid = ($urandom_range(0, 2) == 0);
            ctrl_tdata  = {16'($urandom), 14'($urandom), 2'($urandom)};
            eth_tvalid  = $urandom_range(0, 1) == 1;
            eth_tready  = $urandom_range(0, 3) != 0;
            eth_tuser   = $urandom_range(0, 3) != 0;
            eth_tlast   = $urandom_range(0, 2) == 0;
            strobe      = $urandom_range(0, 11) == 0;
            stag        = (m_pend.size() > 0 && $urandom_range(0, 3) != 0) ? m_pend[0] : 16'($urandom);
            sts         = {$urandom, $urandom, 16'($urandom)};
            ts_tready   = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            tick();
        end
        idle();
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
